// File: rtl/fetch_pc_if.sv
// Fetch-PC request bus between the PC generator (master) and the fetch stage (slave).
// With PC_ADDR_EXC_EN defined the bus also carries the addr_exc flag.
interface fetch_pc_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int FETCH_WIDTH = 2
);
   localparam int CW = $clog2(FETCH_WIDTH) + 1;

   logic                  flush;
   logic [ADDR_WIDTH-1:0] flush_pc;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  pred_taken;
   logic [ADDR_WIDTH-1:0] pred_pc;
   logic                  halt;
   logic                  ready;
   logic                  valid;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic [CW-1:0]         fetch_count;
`ifdef PC_ADDR_EXC_EN
   logic                  addr_exc;

   modport master (
      input  flush, flush_pc, redirect, redirect_pc, pred_taken, pred_pc, halt, ready,
      output valid, pc_out, fetch_count, addr_exc
   );
   modport slave (
      output flush, flush_pc, redirect, redirect_pc, pred_taken, pred_pc, halt, ready,
      input  valid, pc_out, fetch_count, addr_exc
   );
`else
   modport master (
      input  flush, flush_pc, redirect, redirect_pc, pred_taken, pred_pc, halt, ready,
      output valid, pc_out, fetch_count
   );
   modport slave (
      output flush, flush_pc, redirect, redirect_pc, pred_taken, pred_pc, halt, ready,
      input  valid, pc_out, fetch_count
   );
`endif
endinterface

// File: rtl/fetch_pc_gen.sv
// Front-end PC generator: flush > redirect > predictor > sequential next-PC selection.
// PC_ADDR_EXC_EN keeps misaligned targets and flags them on addr_exc instead of aligning.
//
// state   | meaning
// S_RESET | held in reset, valid=0, pc=INIT_PC
// S_RUN   | pc_out is a live fetch request
// S_HALT  | waiting for flush/redirect, valid=0
module fetch_pc_gen #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] INIT_PC     = ADDR_WIDTH'(32'hbfc0_0000),
   parameter int                    FETCH_WIDTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   fetch_pc_if.master bus
);
   localparam int CW    = $clog2(FETCH_WIDTH) + 1;
   localparam int LOG_G = $clog2(FETCH_WIDTH) + 2;
   localparam logic [ADDR_WIDTH-1:0] G_BYTES    = ADDR_WIDTH'(FETCH_WIDTH * 4);
   localparam logic [ADDR_WIDTH-1:0] BASE_MASK  = {ADDR_WIDTH{1'b1}} << LOG_G;
`ifdef PC_ADDR_EXC_EN
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}};
`else
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << 2;
`endif

   typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [ADDR_WIDTH-1:0] w_seq_pc;
   logic [LOG_G-1:0]      w_low;
   logic [CW-1:0]         w_off;
   logic                  w_fire;
   logic                  w_jump;

   assign w_fire   = (r_state == S_RUN) && bus.ready;
   assign w_jump   = bus.flush || bus.redirect;
   // Wraps naturally at the top of the address space.
   assign w_seq_pc = (r_pc & BASE_MASK) + G_BYTES;
   assign w_low    = r_pc[LOG_G-1:0];
   assign w_off    = CW'(w_low >> 2);

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_RESET;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RESET: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_jump)                 w_state_nxt = S_RUN;
            else if (w_fire && bus.halt) w_state_nxt = S_HALT;
         end
         S_HALT:  if (w_jump) w_state_nxt = S_RUN;
         default: w_state_nxt = S_RESET;
      endcase
   end

   always_comb begin
      w_pc_nxt = r_pc;
      if (bus.flush)                      w_pc_nxt = bus.flush_pc & ALIGN_MASK;
      else if (bus.redirect)              w_pc_nxt = bus.redirect_pc & ALIGN_MASK;
      else if (w_fire && bus.pred_taken)  w_pc_nxt = bus.pred_pc & ALIGN_MASK;
      else if (w_fire)                    w_pc_nxt = w_seq_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) r_pc <= INIT_PC;
      else      r_pc <= w_pc_nxt;
   end

`ifdef PC_ADDR_EXC_EN
   logic r_addr_exc;

   // Sequential advance always lands aligned, so any load re-evaluates the flag.
   always_ff @(posedge clk) begin
      if (!rst)                r_addr_exc <= 1'b0;
      else if (w_jump || w_fire) r_addr_exc <= |w_pc_nxt[1:0];
   end
`endif

   always_comb begin
      bus.valid       = (r_state == S_RUN);
      bus.pc_out      = r_pc;
      bus.fetch_count = CW'(FETCH_WIDTH) - w_off;
`ifdef PC_ADDR_EXC_EN
      bus.addr_exc    = r_addr_exc;
      if (r_addr_exc) bus.fetch_count = CW'(1);
`endif
   end
endmodule
